// File: rtl/kgp_risc_pkg.sv
// Shared widths, reset PC and the fetch-buffer entry type for the KGP_RISC front end.
package kgp_risc_pkg;

    localparam int ADDR_W  = 13;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC = 13'h0000;
    localparam logic [ADDR_W-1:0] PC_INC   = 13'd4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO with a flush input; the head entry is visible combinationally.
module fetch_buffer #(
    parameter int DEPTH = 2,
    parameter type T = logic,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  T                 push_data,
    output T                 head_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push)   wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !clear && !do_pop && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/instr_fetch_unit.sv
// PC register and fetch stage: credit-limited in-order requests, response buffering
// for decode, and stale-response discard after a redirect.
module instr_fetch_unit
    import kgp_risc_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  pc_plus4
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int SUM_W = CNT_W + 2;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q, discard_d;
    logic [CNT_W-1:0]  buf_count, pend_count;
    logic [ADDR_W-1:0] pend_head;
    fetch_entry_t      head_entry, push_entry;
    logic              dec_pop, rsp_drop, rsp_keep, credit_ok;
    logic [SUM_W-1:0]  credits_used;

    assign if_valid = (buf_count != '0);
    assign dec_pop  = if_valid && if_ready;

    // A decode pop this cycle frees its slot, which is what sustains one fetch per cycle.
    assign credits_used = SUM_W'(outstanding_q) + SUM_W'(buf_count)
                        + SUM_W'(discard_q) - SUM_W'(dec_pop);
    assign credit_ok    = credits_used < SUM_W'(BUF_DEPTH);
    assign imem_req     = rst_n && !redirect_valid && credit_ok;
    assign imem_addr    = fetch_pc_q;

    assign rsp_drop = imem_rvalid && (discard_q != '0);
    assign rsp_keep = imem_rvalid && (discard_q == '0) && !redirect_valid;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (redirect_valid) begin
            fetch_pc_d    = redirect_pc & ~ADDR_W'(3);
            outstanding_d = '0;
            discard_d     = outstanding_q + discard_q - CNT_W'(imem_rvalid);
        end else begin
            if (imem_req) fetch_pc_d = fetch_pc_q + PC_INC;
            outstanding_d = outstanding_q + CNT_W'(imem_req) - CNT_W'(imem_rvalid && !rsp_drop);
            discard_d     = discard_q - CNT_W'(rsp_drop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // Request PCs stay queued across redirects so each response can be matched or dropped.
    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .T     (logic [ADDR_W-1:0])
    ) u_pend_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (imem_req),
        .pop       (imem_rvalid),
        .clear     (1'b0),
        .push_data (fetch_pc_q),
        .head_data (pend_head),
        .count     (pend_count)
    );

    assign push_entry = '{pc: pend_head, instr: imem_rdata};

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .T     (fetch_entry_t)
    ) u_instr_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_keep),
        .pop       (dec_pop),
        .clear     (redirect_valid),
        .push_data (push_entry),
        .head_data (head_entry),
        .count     (buf_count)
    );

    assign if_instr = if_valid ? head_entry.instr : '0;
    assign if_pc    = if_valid ? head_entry.pc : RESET_PC;
    assign pc_plus4 = if_pc + PC_INC;

    assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rvalid && (pend_count == '0)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model plus a scoreboard of expected decode entries.
module tb_instr_fetch_unit;
    import kgp_risc_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rvalid = 1'b0;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;
    logic [ADDR_W-1:0]  pc_plus4;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int lat          = 1;
    int req_cnt      = 0;

    typedef struct { logic [ADDR_W-1:0] addr; int due; } mreq_t;
    typedef struct { logic [ADDR_W-1:0] pc; logic [INSTR_W-1:0] instr; } exp_t;

    mreq_t mq[$];
    exp_t  sb[$];

    instr_fetch_unit #(.BUF_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .pc_plus4       (pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return 32'h1000_0000 + INSTR_W'(a);
    endfunction

    // Memory model and scoreboard: responses driven on the falling edge, DUT sampled 1 unit later.
    always begin
        exp_t e;
        @(negedge clk);
        cyc++;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
        #1;
        if (!rst_n) begin
            mq.delete();
            sb.delete();
        end else begin
            if (if_valid && if_ready) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_pop: got pc=%h instr=%h, required no instruction", if_pc, if_instr);
                end else begin
                    e = sb.pop_front();
                    $display("[TB] cyc %0d decode pc=%h instr=%h", cyc, if_pc, if_instr);
                    if (if_pc !== e.pc || if_instr !== e.instr) begin
                        tests_failed++;
                        $display("FAIL sb_entry: got pc=%h instr=%h, required pc=%h instr=%h",
                                 if_pc, if_instr, e.pc, e.instr);
                    end
                    tests_run++;
                    if (pc_plus4 !== e.pc + PC_INC) begin
                        tests_failed++;
                        $display("FAIL sb_pc_plus4: got %h, required %h", pc_plus4, e.pc + PC_INC);
                    end
                end
            end
            if (redirect_valid) begin
                sb.delete();
                tests_run++;
                if (imem_req !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL redirect_no_req: got imem_req=%b, required 0", imem_req);
                end
            end
            if (imem_req === 1'b1) begin
                tests_run++;
                if (imem_addr[1:0] !== 2'b00) begin
                    tests_failed++;
                    $display("FAIL addr_align: got %h, required low bits 00", imem_addr);
                end
                mq.push_back('{addr: imem_addr, due: cyc + lat});
                sb.push_back('{pc: imem_addr, instr: mem_word(imem_addr)});
                req_cnt++;
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        tests_run++;
        if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b, required 0", imem_req); end
        tests_run++;
        if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b, required 0", if_valid); end
        tests_run++;
        if (if_instr !== '0) begin tests_failed++; $display("FAIL reset_instr: got %h, required 0", if_instr); end
        tests_run++;
        if (if_pc !== RESET_PC) begin tests_failed++; $display("FAIL reset_pc: got %h, required %h", if_pc, RESET_PC); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fetch_seq();
        int n_valid = 0;
        #2;
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 13'h0000) begin
            tests_failed++; $display("FAIL seq_addr0: got req=%b addr=%h, required 1/0000", imem_req, imem_addr);
        end
        tests_run++;
        if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL seq_valid_c0: got %b, required 0", if_valid); end
        @(negedge clk); #2;
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 13'h0004) begin
            tests_failed++; $display("FAIL seq_addr1: got req=%b addr=%h, required 1/0004", imem_req, imem_addr);
        end
        tests_run++;
        if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL seq_valid_c1: got %b, required 0", if_valid); end
        @(negedge clk); #2;
        tests_run++;
        if (if_valid !== 1'b1 || if_pc !== 13'h0000 || pc_plus4 !== 13'h0004) begin
            tests_failed++;
            $display("FAIL seq_first_valid: got valid=%b pc=%h pc4=%h, required 1/0000/0004", if_valid, if_pc, pc_plus4);
        end
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 13'h0008) begin
            tests_failed++; $display("FAIL seq_addr2: got req=%b addr=%h, required 1/0008", imem_req, imem_addr);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #2;
            if (if_valid === 1'b1) n_valid++;
        end
        tests_run++;
        if (n_valid != 6) begin tests_failed++; $display("FAIL seq_throughput: got %0d valid cycles, required 6", n_valid); end
    endtask

    task automatic test_wrap();
        bit seen = 0;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 13'h1FFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        #2;
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 13'h1FFC) begin
            tests_failed++; $display("FAIL wrap_addr0: got req=%b addr=%h, required 1/1ffc", imem_req, imem_addr);
        end
        @(negedge clk); #2;
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 13'h0000) begin
            tests_failed++; $display("FAIL wrap_addr1: got req=%b addr=%h, required 1/0000", imem_req, imem_addr);
        end
        for (int i = 0; i < 10 && !seen; i++) begin
            if (if_valid === 1'b1) seen = 1;
            else begin @(negedge clk); #2; end
        end
        tests_run++;
        if (!seen || if_pc !== 13'h1FFC || pc_plus4 !== 13'h0000) begin
            tests_failed++;
            $display("FAIL wrap_head: got valid=%b pc=%h pc4=%h, required 1/1ffc/0000", if_valid, if_pc, pc_plus4);
        end
        @(negedge clk); #2;
        tests_run++;
        if (if_valid !== 1'b1 || if_pc !== 13'h0000) begin
            tests_failed++; $display("FAIL wrap_next: got valid=%b pc=%h, required 1/0000", if_valid, if_pc);
        end
    endtask

    task automatic test_backpressure();
        int start_reqs;
        @(negedge clk);
        if_ready   = 1'b0;
        start_reqs = req_cnt;
        for (int i = 0; i < 5; i++) begin
            #2;
            tests_run++;
            if (if_valid !== 1'b1 || sb.size() == 0) begin
                tests_failed++; $display("FAIL bp_valid: got valid=%b, required 1 with queued entry", if_valid);
            end else if (if_pc !== sb[0].pc || if_instr !== sb[0].instr) begin
                tests_failed++;
                $display("FAIL bp_hold: got pc=%h instr=%h, required pc=%h instr=%h", if_pc, if_instr, sb[0].pc, sb[0].instr);
            end
            if (i >= 2) begin
                tests_run++;
                if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL bp_no_credit: got req=%b, required 0", imem_req); end
            end
            @(negedge clk);
        end
        tests_run++;
        if (req_cnt - start_reqs > 2) begin
            tests_failed++; $display("FAIL bp_req_count: got %0d requests, required at most 2", req_cnt - start_reqs);
        end
        if_ready = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_redirect_collide();
        bit seen = 0;
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 13'h0103;
        #2;
        tests_run++;
        if (imem_rvalid !== 1'b1 || if_valid !== 1'b1) begin
            tests_failed++; $display("FAIL collide_setup: got rvalid=%b valid=%b, required 1/1", imem_rvalid, if_valid);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #2;
        tests_run++;
        if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL collide_flush: got valid=%b, required 0", if_valid); end
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 13'h0100) begin
            tests_failed++; $display("FAIL collide_addr: got req=%b addr=%h, required 1/0100", imem_req, imem_addr);
        end
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk); #2;
            if (if_valid === 1'b1) seen = 1;
        end
        tests_run++;
        if (!seen || if_pc !== 13'h0100) begin
            tests_failed++; $display("FAIL collide_head: got valid=%b pc=%h, required 1/0100", if_valid, if_pc);
        end
    endtask

    task automatic test_redirect_inflight();
        bit ready_pt = 0;
        bit seen = 0;
        lat = 3;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 20 && !ready_pt; i++) begin
            @(negedge clk); #2;
            if (mq.size() == 2) ready_pt = 1;
        end
        tests_run++;
        if (!ready_pt) begin tests_failed++; $display("FAIL inflight_setup: got %0d in flight, required 2", mq.size()); end
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 13'h0100;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            #2;
            if (if_valid === 1'b1) seen = 1;
            else @(negedge clk);
        end
        tests_run++;
        if (!seen || if_pc !== 13'h0100 || if_instr !== 32'h1000_0100) begin
            tests_failed++;
            $display("FAIL inflight_head: got valid=%b pc=%h instr=%h, required 1/0100/10000100", if_valid, if_pc, if_instr);
        end
        lat = 1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_midstream_reset();
        bit ready_pt = 0;
        bit seen = 0;
        lat = 3;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 10 && !ready_pt; i++) begin
            @(negedge clk); #2;
            if (mq.size() >= 1) ready_pt = 1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        tests_run++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            tests_failed++; $display("FAIL mrst_ctrl: got req=%b valid=%b, required 0/0", imem_req, if_valid);
        end
        tests_run++;
        if (if_instr !== '0 || if_pc !== RESET_PC) begin
            tests_failed++; $display("FAIL mrst_data: got instr=%h pc=%h, required 0/%h", if_instr, if_pc, RESET_PC);
        end
        repeat (2) @(negedge clk);
        lat = 1;
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            tests_failed++; $display("FAIL mrst_restart: got req=%b addr=%h, required 1/%h", imem_req, imem_addr, RESET_PC);
        end
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk); #2;
            if (if_valid === 1'b1) seen = 1;
        end
        tests_run++;
        if (!seen || if_pc !== RESET_PC) begin
            tests_failed++; $display("FAIL mrst_head: got valid=%b pc=%h, required 1/%h", if_valid, if_pc, RESET_PC);
        end
        repeat (4) @(negedge clk);
        #2;
        tests_run++;
        if (sb.size() > 2) begin
            tests_failed++; $display("FAIL credit_bound: got %0d pending+buffered, required at most 2", sb.size());
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b1;
        test_reset();
        test_fetch_seq();
        test_wrap();
        test_backpressure();
        test_redirect_collide();
        test_redirect_inflight();
        test_midstream_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
